instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/troy_fetch_pkg.sv | 28 ++
 rtl/fetch_buffer.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/troy_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its buffer.
package troy_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [ADDR_W-1:0] DEFAULT_PC_STEP  = 32'd4;

  // S_FETCH: normal operation. S_DROP: one response is still owed by memory
  // for a request that a redirect made obsolete; it is swallowed on arrival.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_DROP  = 1'b1
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} entries sitting between memory and decode.
// Flush empties it in one cycle; reset additionally clears the storage so the
// head reads as zero.
module fetch_buffer
  import troy_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 entry_in,
  input  logic                         pop,
  input  logic                         flush,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output fetch_entry_t                 head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign push_ok = push && ((count != FULL) || pop);
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Pointer, occupancy and storage update.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared only on reset (tiny buffer, and the head must
      // read zero afterwards); flush just rewinds the pointers.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues sequential fetches to instruction
// memory, buffers the returned words for decode, and restarts on redirects,
// discarding a response that is still in flight when the redirect arrives.
module instr_fetch_unit
  import troy_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_STEP   = DEFAULT_PC_STEP,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CNT_W = cnt_width(BUF_DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  // Redirect target parked while the obsolete request drains in S_DROP.
  logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;

  logic              buf_push;
  logic              buf_pop;
  logic              buf_flush;
  logic [CNT_W-1:0]  buf_count;
  fetch_entry_t      buf_head;
  fetch_entry_t      buf_in;

  // The outstanding address is always fetch_pc; it only moves on ack or on a
  // redirect with nothing in flight, which keeps a pending request stable.
  assign imem_addr  = fetch_pc_q;
  assign imem_req   = !rst && ((state_q == S_DROP) || (buf_count < FULL));
  assign inst_valid = !rst && (buf_count != '0);
  assign inst       = buf_head.inst;
  assign inst_pc    = buf_head.pc;
  assign buf_in     = '{pc: fetch_pc_q, inst: imem_rdata};
  // Redirect wins over pop: the flushed head is not consumed.
  assign buf_pop    = inst_valid && inst_ready && !redirect;

  // Next-state, next-pc and buffer control.
  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    buf_push     = 1'b0;
    buf_flush    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          buf_flush = 1'b1;
          if (imem_req && !imem_ack) begin
            state_d      = S_DROP;
            pending_pc_d = redirect_pc;
          end else begin
            fetch_pc_d = redirect_pc;
          end
        end else if (imem_req && imem_ack) begin
          buf_push   = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end
      S_DROP: begin
        if (redirect) begin
          buf_flush = 1'b1;
          if (imem_ack) begin
            state_d    = S_FETCH;
            fetch_pc_d = redirect_pc;
          end else begin
            pending_pc_d = redirect_pc;
          end
        end else if (imem_ack) begin
          state_d    = S_FETCH;
          fetch_pc_d = pending_pc_q;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and address registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .entry_in (buf_in),
    .pop      (buf_pop),
    .flush    (buf_flush),
    .count    (buf_count),
    .head     (buf_head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for the main
// flow, then hand-written sequences for drop, double redirect and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'd0),
    .PC_STEP   (32'd4),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  // One cycle: inputs, then outputs expected during that cycle (before edge).
  typedef struct {
    bit        rst;
    bit        redir;
    bit [31:0] rpc;
    bit        ack;
    bit [31:0] rdata;
    bit        rdy;
    bit        e_req;
    bit [31:0] e_addr;
    bit        e_valid;
    bit        chk_head;
    bit [31:0] e_pc;
    bit [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, bit rd, bit [31:0] rp, bit a, bit [31:0] d,
                             bit y, bit er, bit [31:0] ea, bit ev, bit ch,
                             bit [31:0] ep, bit [31:0] ei);
    vec_t t;
    t = '{r, rd, rp, a, d, y, er, ea, ev, ch, ep, ei};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge and let combinational outputs settle.
  task automatic drive(input bit r, input bit rd, input bit [31:0] rp,
                       input bit a, input bit [31:0] d, input bit y);
    rst = r; redirect = rd; redirect_pc = rp;
    imem_ack = a; imem_rdata = d; inst_ready = y;
    #3;
  endtask

  task automatic expect_out(input string tag, input bit er, input bit [31:0] ea,
                            input bit ev, input bit ch, input bit [31:0] ep,
                            input bit [31:0] ei);
    check({tag, " req"}, {31'd0, imem_req}, {31'd0, er});
    if (er) check({tag, " addr"}, imem_addr, ea);
    check({tag, " valid"}, {31'd0, inst_valid}, {31'd0, ev});
    if (ev || ch) begin
      check({tag, " inst_pc"}, inst_pc, ep);
      check({tag, " inst"}, inst, ei);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst rdy | req addr valid chk pc inst
    // Reset, then streaming with ack every cycle.
    vecs.push_back(v(1,0,0,0,0,0,                  0,0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,                  0,0,0,1,0,0));
    vecs.push_back(v(0,0,0,1,32'h1000_0000,1,      1,32'h0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'h1000_0004,1,      1,32'h4,1,0,32'h0,32'h1000_0000));
    vecs.push_back(v(0,0,0,1,32'h1000_0008,1,      1,32'h8,1,0,32'h4,32'h1000_0004));
    vecs.push_back(v(0,0,0,0,0,1,                  1,32'hC,1,0,32'h8,32'h1000_0008));
    vecs.push_back(v(0,0,0,0,0,1,                  1,32'hC,0,0,0,0));
    // Reset with a request outstanding; ack during reset is ignored.
    vecs.push_back(v(1,0,0,1,32'hBAD0_0000,0,      0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,                  1,32'h0,0,1,0,0));
    // Decode stalls five cycles: buffer fills, requests stop, head holds.
    vecs.push_back(v(0,0,0,1,32'h2000_0000,0,      1,32'h0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'h2000_0004,0,      1,32'h4,1,0,32'h0,32'h2000_0000));
    vecs.push_back(v(0,0,0,0,0,0,                  0,0,1,0,32'h0,32'h2000_0000));
    vecs.push_back(v(0,0,0,0,0,0,                  0,0,1,0,32'h0,32'h2000_0000));
    vecs.push_back(v(0,0,0,0,0,0,                  0,0,1,0,32'h0,32'h2000_0000));
    vecs.push_back(v(0,0,0,0,0,1,                  0,0,1,0,32'h0,32'h2000_0000));
    vecs.push_back(v(0,0,0,1,32'h2000_0008,1,      1,32'h8,1,0,32'h4,32'h2000_0004));
    vecs.push_back(v(0,0,0,0,0,1,                  1,32'hC,1,0,32'h8,32'h2000_0008));
    vecs.push_back(v(0,0,0,0,0,0,                  1,32'hC,0,0,0,0));
    // Redirect to 0x200 together with ack and pop.
    vecs.push_back(v(0,0,0,1,32'h2000_000C,0,      1,32'hC,0,0,0,0));
    vecs.push_back(v(0,1,32'h200,1,32'h2000_0010,1,1,32'h10,1,0,32'hC,32'h2000_000C));
    vecs.push_back(v(0,0,0,0,0,1,                  1,32'h200,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'h3000_0200,1,      1,32'h200,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,1,                  1,32'h204,1,0,32'h200,32'h3000_0200));
    vecs.push_back(v(0,0,0,0,0,1,                  1,32'h204,0,0,0,0));
    // Redirect to the top of the address space; fetch pc wraps to zero.
    vecs.push_back(v(0,1,32'hFFFF_FFFC,1,32'h3000_0204,1,1,32'h204,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'h4FFF_FFFC,1,      1,32'hFFFF_FFFC,0,0,0,0));
    vecs.push_back(v(0,0,0,1,32'h4000_0000,1,      1,32'h0,1,0,32'hFFFF_FFFC,32'h4FFF_FFFC));
    vecs.push_back(v(0,0,0,0,0,1,                  1,32'h4,1,0,32'h0,32'h4000_0000));
    vecs.push_back(v(0,0,0,0,0,0,                  1,32'h4,0,0,0,0));

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
      expect_out($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].chk_head, vecs[i].e_pc, vecs[i].e_inst);
      next_cycle();
    end

    // Redirect to 0x100 while the fetch of 0x4 is outstanding; ack 3 cycles late.
    drive(0, 1, 32'h100, 0, 0, 1); expect_out("drop_a0", 1, 32'h4, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 1);       expect_out("drop_a1", 1, 32'h4, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 1);       expect_out("drop_a2", 1, 32'h4, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 1, 32'hDEAD_0004, 1); expect_out("drop_a3", 1, 32'h4, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 1);       expect_out("drop_a4", 1, 32'h100, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 1, 32'h5000_0100, 1); expect_out("drop_a5", 1, 32'h100, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 1);       expect_out("drop_a6", 1, 32'h104, 1, 0, 32'h100, 32'h5000_0100); next_cycle();

    // Second redirect while draining replaces the pending target.
    drive(0, 1, 32'h300, 0, 0, 1); expect_out("redir2_b0", 1, 32'h104, 0, 0, 0, 0); next_cycle();
    drive(0, 1, 32'h400, 0, 0, 1); expect_out("redir2_b1", 1, 32'h104, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 1, 32'hDEAD_0104, 1); expect_out("redir2_b2", 1, 32'h104, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 1, 32'h6000_0400, 1); expect_out("redir2_b3", 1, 32'h400, 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 1);       expect_out("redir2_b4", 1, 32'h404, 1, 0, 32'h400, 32'h6000_0400); next_cycle();

    // Reset while the fetch of 0x404 is outstanding.
    drive(1, 0, 0, 0, 0, 1);       expect_out("rst_c0", 0, 0, 0, 0, 0, 0); next_cycle();
    drive(1, 0, 0, 1, 32'hBAD0_0404, 1); expect_out("rst_c1", 0, 0, 0, 1, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 1);       expect_out("rst_c2", 1, 32'h0, 0, 1, 0, 0); next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
